// File: rtl/shift_chain_pkg.sv
// Shared definitions for the shift-chain sequencer: FSM state encoding and
// the counter-width helper.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Width needed to count 0 .. width+depth-1 without wrap-around.
  function automatic int cnt_width(input int width, input int depth);
    if (width + depth <= 2) begin
      return 1;
    end
    return $clog2(width + depth);
  endfunction

endpackage

// File: rtl/shift_chain_seq_if.sv
// Word-level handshake bundle for the shift-chain sequencer: input word
// valid/ready, output word valid/ready, stall and busy status.
interface shift_chain_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;

  // Producer/consumer side (drives words in, takes words out).
  modport master (
    output in_valid, in_data, stall, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, stall, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_chain.sv
// DEPTH-stage single-bit shift register with enable and synchronous clear.
// tap[0] is the first stage, tap[DEPTH-1] the tail.
module shift_chain #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [DEPTH-1:0] tap
);

  logic [DEPTH-1:0] tap_q;
  logic [DEPTH-1:0] tap_d;
  logic [DEPTH-1:0] shift_in;

  // Each stage takes its predecessor; stage 0 takes the serial input.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign shift_in[gi] = din;
      end else begin : g_body
        assign shift_in[gi] = tap_q[gi-1];
      end
    end
  endgenerate

  // Next chain contents: shifted when enabled, otherwise held.
  always_comb begin
    tap_d = tap_q;
    if (en) begin
      tap_d = shift_in;
    end
  end

  // Chain register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign tap = tap_q;

endmodule

// File: rtl/shift_chain_seq.sv
// Loopback sequencer: serializes one word MSB-first into a shift chain,
// drains it with zeros while collecting the tail bits, then presents the
// reassembled word. A healthy chain returns the input word unchanged.
module shift_chain_seq
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  shift_chain_seq_if.slave bus,
  output logic [DEPTH-1:0] tap
);

  localparam int CNT_W = cnt_width(WIDTH, DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH + DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             chain_en;
  logic             chain_din;
  logic [DEPTH-1:0] chain_tap;

  shift_chain #(
    .DEPTH(DEPTH)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .en  (chain_en),
    .din (chain_din),
    .tap (chain_tap)
  );

  // Next-state, counter, word and capture logic. The tail is captured from
  // the pre-edge chain once the first injected bit has reached it (cnt >= DEPTH).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    out_data_d = out_data_q;
    chain_en   = 1'b0;
    chain_din  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          word_d     = bus.in_data;
          cnt_d      = '0;
          out_data_d = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!bus.stall) begin
          chain_en  = 1'b1;
          chain_din = (cnt_q < CNT_WIDTH) ? word_q[WIDTH-1] : 1'b0;
          word_d    = {word_q[WIDTH-2:0], 1'b0};
          if (cnt_q >= CNT_DEPTH) begin
            out_data_d = {out_data_q[WIDTH-2:0], chain_tap[DEPTH-1]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers with synchronous clear; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      out_data_q <= out_data_d;
    end
  end

  // Status is decoded from registered state only.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.out_data  = out_data_q;
  assign tap           = chain_tap;

endmodule

// File: tb/tb_shift_chain_seq.sv
// Self-checking bench for shift_chain_seq: directed scenarios plus random
// words and stalls, checked against a word-level model of the chain.
module tb_shift_chain_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [D-1:0] tap;

  shift_chain_seq_if #(.WIDTH(W)) bus ();

  shift_chain_seq #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tap (tap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // After n unstalled shifts, stage k holds the bit injected on shift n-1-k.
  // Injection j is word bit W-1-j for j < W, zero afterwards.
  function automatic logic [D-1:0] model_tap(input logic [W-1:0] w, input int n);
    logic [D-1:0] t;
    t = '0;
    for (int k = 0; k < D; k++) begin
      int j;
      j = n - 1 - k;
      if (j >= 0 && j < W) t[k] = w[W-1-j];
    end
    return t;
  endfunction

  // One complete word: accept, shift (fixed or random stalls), hold in DONE,
  // output handshake.
  task automatic run_word(input logic [W-1:0] w, input bit rand_stall,
                          input int stall_at, input int stall_len, input int hold,
                          input bit keep_valid, input logic [W-1:0] next_data);
    int           n;
    int           stalled;
    int           edges;
    bit           st;
    logic [W-1:0] tails;
    logic [W-1:0] held;
    logic [D-1:0] tap_before;
    n = 0; stalled = 0; edges = 0; tails = '0;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    bus.out_ready = (hold == 0);
    tick;
    bus.in_valid = keep_valid;
    bus.in_data  = next_data;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_in_ready", 32'(bus.in_ready), 32'd0);
    while (!bus.out_valid && edges < 200) begin
      if (rand_stall) st = ($urandom_range(0, 3) == 0);
      else            st = (n == stall_at) && (stalled < stall_len);
      bus.stall  = st;
      tap_before = tap;
      if (!st && n >= D) tails = {tails[W-2:0], tap[D-1]};
      tick;
      edges++;
      if (st) begin
        stalled++;
        check("stall_freeze", 32'(tap), 32'(tap_before));
      end else begin
        n++;
        check($sformatf("tap_n%0d", n), 32'(tap), 32'(model_tap(w, n)));
      end
    end
    bus.stall = 1'b0;
    check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(edges), 32'(W + D + stalled));
    check("out_data", 32'(bus.out_data), 32'(w));
    check("tail_seq", 32'(tails), 32'(w));
    check("drained_tap", 32'(tap), 32'd0);
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    held = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      bus.stall = 1'($urandom_range(0, 1));
      tick;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(w));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.stall     = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    check("hs_in_ready", 32'(bus.in_ready), 32'd1);
    check("hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("hs_busy", 32'(bus.busy), 32'd0);
    $display("txn in=%02h out=%02h latency=%0d stalls=%0d hold=%0d", w, held, edges, stalled, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.stall     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick;
    rst = 1'b0;
    check("rst_tap", 32'(tap), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    $display("txn reset released");

    // Plain word, no stall.
    run_word(8'hA5, 1'b0, -1, 0, 0, 1'b0, 8'h00);
    // Two stalled cycles at cnt=4.
    run_word(8'h3C, 1'b0, 4, 2, 0, 1'b0, 8'h00);
    // Consumer back-pressure with a competing input word held valid.
    run_word(8'hFF, 1'b0, -1, 0, 5, 1'b1, 8'h00);
    run_word(8'h00, 1'b0, -1, 0, 0, 1'b0, 8'h00);

    // Reset in the middle of SHIFT at cnt=5.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick;
    bus.in_valid = 1'b0;
    repeat (5) tick;
    check("pre_rst_tap", 32'(tap), 32'(model_tap(8'h5A, 5)));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_tap", 32'(tap), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    $display("txn reset mid-shift");
    run_word(8'h81, 1'b0, -1, 0, 0, 1'b0, 8'h00);

    // Back-to-back words with out_ready tied high.
    run_word(8'h01, 1'b0, -1, 0, 0, 1'b1, 8'h80);
    run_word(8'h80, 1'b0, -1, 0, 0, 1'b0, 8'h00);

    // Random words, random stalls, random consumer hold.
    for (int r = 0; r < 12; r++) begin
      run_word(W'($urandom), 1'b1, -1, 0, int'($urandom_range(0, 3)), 1'b0, 8'h00);
    end

    // Nothing further should be in flight.
    repeat (3) tick;
    check("final_busy", 32'(bus.busy), 32'd0);
    check("final_in_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/shift_chain_seq.md
# shift_chain_seq

Sequencer for a DEPTH-stage single-bit shift chain (din → stage 0 → … → stage DEPTH-1). It accepts one WIDTH-bit word over a valid/ready handshake and serializes it MSB-first into the chain. It then drains the chain with zeros while capturing the tail bit into an output word, and presents the reassembled word over a second valid/ready handshake. It is the loopback/exercise controller for the team's nonblocking shift pipelines: a correct chain returns the input word unchanged after a fixed latency.

## Interface
- WIDTH, 8, bits per word (≥2)
- DEPTH, 3, shift-chain stages (≥1)
- CNT_W, $clog2(WIDTH+DEPTH), counter width (derived, not overridden)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word offered
- in_data  in  WIDTH  input word
- in_ready  out  1  high only in IDLE
- stall  in  1  freezes chain and counter while in SHIFT
- out_valid  out  1  high only in DONE
- out_data  out  WIDTH  reassembled word
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in SHIFT or DONE
- tap  out  DEPTH  chain contents; tap[0] = first stage, tap[DEPTH-1] = tail

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid: latch word ← in_data, cnt ← 0, out_data ← 0, go to SHIFT.
- SHIFT, stall=0, each cycle:
  - Chain shifts. Stage 0 ← word[WIDTH-1] if cnt<WIDTH, else 0. Stage k ← stage k-1.
  - word shifts left by 1.
  - If cnt ≥ DEPTH: out_data ← {out_data[WIDTH-2:0], tail}, where tail is the pre-edge tap[DEPTH-1].
  - If cnt = WIDTH+DEPTH-1: go to DONE. Otherwise cnt ← cnt+1.
- SHIFT, stall=1: chain, word, cnt and out_data all hold. The state stays SHIFT.
- Stall is ignored outside SHIFT.
- DONE: out_valid=1 and out_data is held stable. On out_ready: go to IDLE. While in DONE, in_valid is ignored.
- At DONE the chain is all zeros, because the last DEPTH injections were 0.
- Arithmetic: cnt is unsigned CNT_W bits and never exceeds WIDTH+DEPTH-1, so there is no wrap-around.

## Timing
- Reset: at an edge with rst=1, all of the following are cleared, regardless of state or stall:
  - state=IDLE
  - tap=0, word=0, cnt=0
  - out_data=0
  - out_valid=0, busy=0
  - in_ready=1, combinational from state, so it reads 1 after the reset edge
- Reset mid-SHIFT or mid-DONE aborts the word silently. Nothing is output.
- Accept edge is E0. SHIFT occupies the cycles after E0 up to edge E(WIDTH+DEPTH).
- With no stalls, out_valid is high from edge E(WIDTH+DEPTH): 11 cycles for the defaults. Each stalled cycle adds 1.
- Output handshake at edge Eh: in_ready is high from Eh. The next word's accept is no earlier than Eh+1, so there is no overlap.
- in_ready, out_valid and busy are decoded from registered state only. No combinational path from in_valid or out_ready.
- Simultaneous rst and any handshake: rst wins.

## Structure
- Shared package shift_chain_pkg holds:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - a count-width helper function
- One sub-module: shift_chain. It is a DEPTH-stage enabled shift register with synchronous clear, built with nonblocking assignments. Ports: clk, rst, en, din, tap.
- shift_chain_seq contains the FSM, counter, word/capture registers, and one shift_chain instance.

## Test plan
1. Reset held 3 cycles, then released → tap=0, out_data=0, out_valid=0, busy=0, in_ready=1.
2. in_data=8'hA5, no stall, out_ready=1 → out_valid rises exactly 11 edges after the accept edge, out_data=8'hA5, and the tail bit sequence is 1,0,1,0,0,1,0,1.
3. in_data=8'h3C with stall=1 for 2 cycles at cnt=4 → out_valid at 13 edges, out_data=8'h3C, taps frozen during the stall.
4. in_data=8'hFF, out_ready=0 for 5 cycles in DONE, in_valid=1 with in_data=8'h00 throughout → out_data stays 8'hFF, in_ready=0, the second word is accepted only one edge after the handshake, and it returns 8'h00.
5. rst asserted for 1 cycle while in SHIFT at cnt=5 → next cycle all outputs are at reset values. A following word 8'h81 returns 8'h81 with normal latency.
6. Back-to-back words 8'h01 and 8'h80 with out_ready tied 1 → each word completes in 11 cycles after its accept, results match, and no word is dropped or duplicated.
